// File: rtl/mux2to1_arbiter.sv
// mux2to1_arbiter: two-requester round-robin arbiter steering a registered 2:1 mux; ARB_HOLD_LIMIT_EN caps a contended grant at HOLD_MAX cycles.
// Latency: grant 1 cycle after the request is sampled, y/y_valid 1 cycle after the grant cycle.
// Backpressure: none; a requester waits, holding its req, while the other owns the path.
module mux2to1_arbiter #(
   parameter int WIDTH    = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] y,
   output logic             y_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_A = 2'b01,
      GNT_B = 2'b10
   } state_t;

   localparam logic SERVED_A = 1'b0;
   localparam logic SERVED_B = 1'b1;

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
      $error("mux2to1_arbiter: HOLD_MAX must be in 1..255");
   end

   state_t state;
   state_t state_nxt;
   logic   last_served;
   logic   last_served_nxt;
   logic   hold_expired;

`ifdef ARB_HOLD_LIMIT_EN
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   logic [7:0] hold_cnt;
   logic [7:0] hold_cnt_nxt;

   assign hold_expired = (hold_cnt == HOLD_LAST);

   // Counter restarts whenever the grant changes hands or drops to IDLE.
   always_comb begin
      hold_cnt_nxt = 8'd0;
      if ((state_nxt == state) && (state != IDLE)) begin
         if (hold_cnt != HOLD_LAST) begin
            hold_cnt_nxt = hold_cnt + 8'd1;
         end else begin
            hold_cnt_nxt = hold_cnt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= 8'd0;
      end else begin
         hold_cnt <= hold_cnt_nxt;
      end
   end
`else
   assign hold_expired = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_a && req_b) begin
               state_nxt = (last_served == SERVED_B) ? GNT_A : GNT_B;
            end else if (req_a) begin
               state_nxt = GNT_A;
            end else if (req_b) begin
               state_nxt = GNT_B;
            end else begin
               state_nxt = IDLE;
            end
         end
         GNT_A: begin
            if (req_a) begin
               state_nxt = (hold_expired && req_b) ? GNT_B : GNT_A;
            end else begin
               state_nxt = req_b ? GNT_B : IDLE;
            end
         end
         GNT_B: begin
            if (req_b) begin
               state_nxt = (hold_expired && req_a) ? GNT_A : GNT_B;
            end else begin
               state_nxt = req_a ? GNT_A : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      last_served_nxt = last_served;
      if (state == GNT_A) begin
         last_served_nxt = SERVED_A;
      end else if (state == GNT_B) begin
         last_served_nxt = SERVED_B;
      end
   end

   // Reset leaves B as last served so the first tie after reset goes to A.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_served <= SERVED_B;
      end else begin
         state       <= state_nxt;
         last_served <= last_served_nxt;
      end
   end

   assign gnt_a = (state == GNT_A);
   assign gnt_b = (state == GNT_B);
   assign sel   = (state == GNT_B);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y       <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= gnt_a | gnt_b;
         if (gnt_a | gnt_b) begin
            y <= sel ? b : a;
         end
      end
   end

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// tb_mux2to1_arbiter: directed bench with an ownership/queue-level reference model and per-cycle compare.
// Latency: model predicts grant one edge after request and data one edge after grant.
// Backpressure: not applicable; requests are driven directly.
module tb_mux2to1_arbiter;

   localparam int WIDTH    = 8;
   localparam int HOLD_MAX = 4;
`ifdef ARB_HOLD_LIMIT_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             req_a;
   logic             req_b;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             gnt_a;
   logic             gnt_b;
   logic             sel;
   logic [WIDTH-1:0] y;
   logic             y_valid;

   int cmp_cnt = 0;
   int err_cnt = 0;
   bit chk_en  = 1'b0;

   mux2to1_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_a   (req_a),
      .req_b   (req_b),
      .a       (a),
      .b       (b),
      .gnt_a   (gnt_a),
      .gnt_b   (gnt_b),
      .sel     (sel),
      .y       (y),
      .y_valid (y_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: who owns the path (0 none, 1 A, 2 B), who was served last,
   // and how many cycles the current owner has already completed.
   int               m_own;
   int               m_last;
   int               m_run;
   logic [WIDTH-1:0] m_y;
   logic             m_yv;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_own  = 0;
         m_last = 2;
         m_run  = 0;
         m_y    = '0;
         m_yv   = 1'b0;
      end else begin
         int  nxt;
         bit  mine;
         bit  other;
         m_yv = (m_own != 0);
         if (m_own == 1) m_y = a;
         if (m_own == 2) m_y = b;
         if (m_own != 0) m_last = m_own;
         mine  = (m_own == 1) ? req_a : (m_own == 2) ? req_b : 1'b0;
         other = (m_own == 1) ? req_b : (m_own == 2) ? req_a : 1'b0;
         if (m_own == 0) begin
            if (req_a && req_b) nxt = (m_last == 1) ? 2 : 1;
            else if (req_a)     nxt = 1;
            else if (req_b)     nxt = 2;
            else                nxt = 0;
         end else if (mine) begin
            nxt = (HOLD_EN && (m_run + 1 >= HOLD_MAX) && other) ? 3 - m_own : m_own;
         end else begin
            nxt = other ? 3 - m_own : 0;
         end
         m_run = (nxt != 0 && nxt == m_own) ? m_run + 1 : 0;
         m_own = nxt;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_gnt_a", gnt_a, m_own == 1);
         chk("model_gnt_b", gnt_b, m_own == 2);
         chk("model_sel", sel, m_own == 2);
         chk("model_y_valid", y_valid, m_yv);
         chk("model_y", y, m_y);
         chk("inv_no_double_grant", gnt_a & gnt_b, 0);
         chk("inv_sel_is_gnt_b", sel, gnt_b);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_a = 1'b0;
      req_b = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = 1'b0;
      req_b = 1'b0;
      a     = '0;
      b     = '0;
      step();
      chk_en = 1'b1;
      step();
      chk("rst_gnt_a", gnt_a, 0);
      chk("rst_gnt_b", gnt_b, 0);
      chk("rst_y", y, 0);
      chk("rst_y_valid", y_valid, 0);
      rst_n = 1'b1;
      step();

      // Single requester: three grant cycles, data trails by one
      req_a = 1'b1;
      a     = 8'h5A;
      step();
      chk("single_gnt_first", gnt_a, 1);
      chk("single_yv_first", y_valid, 0);
      step();
      chk("single_y_2", y, 8'h5A);
      chk("single_yv_2", y_valid, 1);
      step();
      chk("single_gnt_3", gnt_a, 1);
      req_a = 1'b0;
      step();
      chk("single_idle_gnt", gnt_a, 0);
      chk("single_last_yv", y_valid, 1);
      step();
      chk("single_yv_drop", y_valid, 0);
      chk("single_y_hold", y, 8'h5A);

      // Tie round-robin from reset: A first, then B
      do_reset();
      step();
      req_a = 1'b1;
      req_b = 1'b1;
      step();
      chk("tie1_gnt_a", gnt_a, 1);
      req_a = 1'b0;
      req_b = 1'b0;
      step();
      req_a = 1'b1;
      req_b = 1'b1;
      step();
      chk("tie2_gnt_b", gnt_b, 1);
      req_a = 1'b0;
      req_b = 1'b0;
      step();
      chk("tie2_idle", gnt_b, 0);

      // Direct switch A -> B with no IDLE bubble
      a     = 8'h11;
      b     = 8'h22;
      req_a = 1'b1;
      step();
      req_b = 1'b1;
      step();
      chk("sw_gnt_a", gnt_a, 1);
      req_a = 1'b0;
      step();
      chk("sw_gnt_b", gnt_b, 1);
      chk("sw_sel", sel, 1);
      chk("sw_yv_a", y_valid, 1);
      chk("sw_y_a", y, 8'h11);
      step();
      chk("sw_yv_b", y_valid, 1);
      chk("sw_y_b", y, 8'h22);
      req_b = 1'b0;
      step();
      step();

      // Both requesting continuously: preempt every HOLD_MAX cycles when enabled
      do_reset();
      a     = 8'hAA;
      b     = 8'hBB;
      req_a = 1'b1;
      req_b = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("hold_gnt_a", gnt_a, HOLD_EN ? (((i / 4) % 2) == 0) : 1);
         if (i > 0) begin
            chk("hold_y", y, (HOLD_EN && (((i - 1) / 4) % 2) == 1) ? 8'hBB : 8'hAA);
         end
      end
      req_a = 1'b0;
      req_b = 1'b0;
      step();
      step();

      // Reset mid-GNT_B between edges drops everything at once
      b     = 8'h3C;
      req_b = 1'b1;
      step();
      step();
      chk("pre_rst_y", y, 8'h3C);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_gnt_b", gnt_b, 0);
      chk("midrst_sel", sel, 0);
      chk("midrst_y", y, 0);
      chk("midrst_yv", y_valid, 0);
      req_a = 1'b1;
      req_b = 1'b1;
      step();
      chk("rst_held_gnt_b", gnt_b, 0);
      #2;
      rst_n = 1'b1;
      step();
      chk("post_rst_tie_a", gnt_a, 1);
      req_a = 1'b0;
      req_b = 1'b0;
      step();
      step();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
